// File: rtl/ysyx_2022040010_axi_arb.sv
// Two-requester AXI4 single-beat arbiter: the instruction-fetch side (read-only) and the
// data side (read/write) share one master port, with round-robin grant when both are pending.
module ysyx_2022040010_axi_arb #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [63:0]     if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [63:0]     d_addr,
  input  logic [2:0]      d_size,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            ar_valid,
  input  logic            ar_ready,
  output logic [AW-1:0]   ar_addr,
  output logic [2:0]      ar_size,
  input  logic            r_valid,
  output logic            r_ready,
  input  logic [DW-1:0]   r_data,
  output logic            aw_valid,
  input  logic            aw_ready,
  output logic [AW-1:0]   aw_addr,
  output logic [2:0]      aw_size,
  output logic            w_valid,
  input  logic            w_ready,
  output logic [DW-1:0]   w_data,
  output logic [DW/8-1:0] w_strb,
  input  logic            b_valid,
  output logic            b_ready
);

  typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              gnt_d_q, gnt_d_d;
  logic              ar_valid_q, ar_valid_d;
  logic [AW-1:0]     ar_addr_q, ar_addr_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic              r_ready_q, r_ready_d;
  logic              aw_valid_q, aw_valid_d;
  logic [AW-1:0]     aw_addr_q, aw_addr_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic              w_valid_q, w_valid_d;
  logic [DW-1:0]     w_data_q, w_data_d;
  logic [DW/8-1:0]   w_strb_q, w_strb_d;
  logic              b_ready_q, b_ready_d;
  logic              aw_ok_q, aw_ok_d;
  logic              w_ok_q, w_ok_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;

  logic              pick_d;
  logic              aw_acc, w_acc;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    gnt_d_d    = gnt_d_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    r_ready_d  = r_ready_q;
    aw_valid_d = aw_valid_q;
    aw_addr_d  = aw_addr_q;
    aw_size_d  = aw_size_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_ready_d  = b_ready_q;
    aw_ok_d    = aw_ok_q;
    w_ok_d     = w_ok_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // D wins when it is alone, or when both are pending and I went last.
    pick_d     = d_req && (!if_req || !last_d_q);
    aw_acc     = aw_ok_q || (aw_valid_q && aw_ready);
    w_acc      = w_ok_q || (w_valid_q && w_ready);

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          if (pick_d && d_we) begin
            state_d    = AWW;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_ok_d    = 1'b0;
            w_ok_d     = 1'b0;
            aw_addr_d  = d_addr[AW-1:0];
            aw_size_d  = d_size;
            w_data_d   = d_wdata;
            w_strb_d   = d_wstrb;
          end else begin
            state_d    = AR;
            ar_valid_d = 1'b1;
            ar_addr_d  = pick_d ? d_addr[AW-1:0] : if_addr[AW-1:0];
            ar_size_d  = pick_d ? d_size : 3'd2;
          end
        end
      end
      AR: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = R;
        end
      end
      R: begin
        if (r_valid) begin
          r_ready_d = 1'b0;
          if (gnt_d_q) d_rdata_d = r_data;
          else         if_rdata_d = r_data;
          d_done_d  = gnt_d_q;
          if_done_d = !gnt_d_q;
          state_d   = RESP;
        end
      end
      AWW: begin
        // Address and data channels complete independently; leave once both are in.
        if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && w_ready)   w_valid_d  = 1'b0;
        aw_ok_d = aw_acc;
        w_ok_d  = w_acc;
        if (aw_acc && w_acc) begin
          b_ready_d = 1'b1;
          state_d   = B;
        end
      end
      B: begin
        if (b_valid) begin
          b_ready_d = 1'b0;
          d_done_d  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      gnt_d_q    <= 1'b0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_ready_q  <= 1'b0;
      aw_ok_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      gnt_d_q    <= gnt_d_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      r_ready_q  <= r_ready_d;
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      aw_size_q  <= aw_size_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_ready_q  <= b_ready_d;
      aw_ok_q    <= aw_ok_d;
      w_ok_q     <= w_ok_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_rdata = if_rdata_q;
  assign d_done   = d_done_q;
  assign d_rdata  = d_rdata_q;
  assign ar_valid = ar_valid_q;
  assign ar_addr  = ar_addr_q;
  assign ar_size  = ar_size_q;
  assign r_ready  = r_ready_q;
  assign aw_valid = aw_valid_q;
  assign aw_addr  = aw_addr_q;
  assign aw_size  = aw_size_q;
  assign w_valid  = w_valid_q;
  assign w_data   = w_data_q;
  assign w_strb   = w_strb_q;
  assign b_ready  = b_ready_q;

  // Only the low AW address bits reach the bus.
  if (AW < 64) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[63:AW], d_addr[63:AW]};
  end

endmodule

// File: tb/tb_ysyx_2022040010_axi_arb.sv
// Directed bench for the I/D AXI arbiter: a small reactive AXI slave, expectation queues
// filled by the stimulus, and a monitor that checks every handshake and done pulse.
module tb_ysyx_2022040010_axi_arb;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_done;
  logic [63:0]     if_addr;
  logic [DW-1:0]   if_rdata;
  logic            d_req, d_we, d_done;
  logic [63:0]     d_addr;
  logic [2:0]      d_size;
  logic [DW-1:0]   d_wdata, d_rdata;
  logic [DW/8-1:0] d_wstrb;
  logic            ar_valid, ar_ready, r_valid, r_ready;
  logic [AW-1:0]   ar_addr, aw_addr;
  logic [2:0]      ar_size, aw_size;
  logic [DW-1:0]   r_data, w_data;
  logic            aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [DW/8-1:0] w_strb;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        is_d;
    logic [63:0] data;
  } done_t;

  done_t       exp_done[$];
  logic [34:0] exp_ar[$];
  logic [34:0] exp_aw[$];
  logic [71:0] exp_w[$];

  always #5 clk = ~clk;

  ysyx_2022040010_axi_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_done(d_done), .d_rdata(d_rdata),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready)
  );

  // Slave memory image: one fixed word, otherwise {~addr, addr}.
  function automatic logic [63:0] resp_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 64'h13 : {~a, a};
  endfunction

  logic r_pend, r_stall, aw_got, w_got, b_pend;
  logic aw_now, w_now;
  assign r_valid = r_pend && !r_stall;
  assign b_valid = b_pend;
  assign aw_now  = aw_got || (aw_valid && aw_ready);
  assign w_now   = w_got || (w_valid && w_ready);

  always @(posedge clk) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_data <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      if (ar_valid && ar_ready) begin
        r_pend <= 1'b1;
        r_data <= resp_data(ar_addr);
      end else if (r_valid && r_ready) begin
        r_pend <= 1'b0;
      end
      if (b_valid && b_ready) begin
        b_pend <= 1'b0;
      end else if (aw_now && w_now) begin
        b_pend <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        aw_got <= aw_now;
        w_got  <= w_now;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // Monitor: every handshake and done pulse must match the head of its queue.
  always @(negedge clk) begin
    done_t e;
    if (!rst) begin
      if (if_done || d_done) begin
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else begin
          e = exp_done.pop_front();
          chk("done_side", {62'b0, if_done, d_done}, e.is_d ? 64'd1 : 64'd2);
          chk("done_rdata", e.is_d ? d_rdata : if_rdata, e.data);
          $display("done: side=%s rdata=%h", e.is_d ? "D" : "I", e.is_d ? d_rdata : if_rdata);
        end
      end
      if (ar_valid && ar_ready) begin
        if (exp_ar.size() == 0) fail_now("ar_unexpected");
        else chk("ar_addr_size", {29'b0, ar_addr, ar_size}, {29'b0, exp_ar.pop_front()});
      end
      if (aw_valid && aw_ready) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else chk("aw_addr_size", {29'b0, aw_addr, aw_size}, {29'b0, exp_aw.pop_front()});
      end
      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          logic [71:0] ew;
          ew = exp_w.pop_front();
          chk("w_data", w_data, ew[71:8]);
          chk("w_strb", {56'b0, w_strb}, {56'b0, ew[7:0]});
        end
      end
    end
  end

  task automatic push_rd(input logic is_d, input logic [31:0] a, input logic [2:0] sz,
                         input logic [63:0] data);
    exp_ar.push_back({a, sz});
    exp_done.push_back({is_d, data});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valids"}, {57'b0, ar_valid, r_ready, aw_valid, w_valid, b_ready, if_done, d_done}, 64'd0);
    chk({tag, "_addrs"}, {ar_addr, aw_addr}, 64'd0);
    chk({tag, "_sizes_strb"}, {50'b0, ar_size, aw_size, w_strb}, 64'd0);
    chk({tag, "_w_data"}, w_data, 64'd0);
    chk({tag, "_rdata"}, if_rdata | d_rdata, 64'd0);
  endtask

  // Requester models: hold req until done, then drop it or move to the next address.
  task automatic i_proc(input int n, input logic [31:0] a0, output int lat);
    int cyc;
    lat = -1;
    if_addr = {32'h0, a0};
    if_req  = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        if (!if_done) cyc++;
      end while (!if_done && cyc <= 60);
      if (cyc > 60) begin
        chk("if_done_timeout", 64'(cyc), 64'd0);
        if_req = 1'b0;
        return;
      end
      if (k == 0) lat = cyc;
      @(posedge clk); #1;
      if (k == n - 1) if_req = 1'b0;
      else if_addr = if_addr + 64'd4;
    end
  endtask

  task automatic d_proc(input int n, input logic we, input logic [31:0] a0, input logic [31:0] step,
                        input logic [2:0] sz, input logic [63:0] wd, input logic [7:0] ws,
                        output int lat);
    int cyc;
    lat = -1;
    d_addr  = {32'h0, a0};
    d_we    = we;
    d_size  = sz;
    d_wdata = wd;
    d_wstrb = ws;
    d_req   = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        if (!d_done) cyc++;
      end while (!d_done && cyc <= 60);
      if (cyc > 60) begin
        chk("d_done_timeout", 64'(cyc), 64'd0);
        d_req = 1'b0;
        return;
      end
      if (k == 0) lat = cyc;
      @(posedge clk); #1;
      if (k == n - 1) begin
        d_req = 1'b0;
        d_we  = 1'b0;
      end else d_addr = d_addr + {32'h0, step};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat_i, lat_d;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = '0; d_wdata = '0; d_wstrb = '0;
    ar_ready = 1'b1; aw_ready = 1'b1; w_ready = 1'b1; r_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single I read at minimum latency
    push_rd(1'b0, 32'h8000_0000, 3'd2, 64'h13);
    i_proc(1, 32'h8000_0000, lat_i);
    chk("t1_latency", 64'(lat_i), 64'd3);

    // 2: simultaneous requests, D first after reset
    push_rd(1'b1, 32'h8000_1000, 3'd3, 64'h7FFF_EFFF_8000_1000);
    push_rd(1'b0, 32'h8000_0004, 3'd2, 64'h7FFF_FFFB_8000_0004);
    fork
      i_proc(1, 32'h8000_0004, lat_i);
      d_proc(1, 1'b0, 32'h8000_1000, 32'd0, 3'd3, 64'd0, 8'h00, lat_d);
    join
    chk("t2_d_latency", 64'(lat_d), 64'd3);
    chk("t2_i_latency", 64'(lat_i), 64'd7);

    // 3: both held high, alternating D,I,D,I,D
    push_rd(1'b1, 32'h8000_1100, 3'd3, 64'h7FFF_EEFF_8000_1100);
    push_rd(1'b0, 32'h8000_0008, 3'd2, 64'h7FFF_FFF7_8000_0008);
    push_rd(1'b1, 32'h8000_1108, 3'd3, 64'h7FFF_EEF7_8000_1108);
    push_rd(1'b0, 32'h8000_000C, 3'd2, 64'h7FFF_FFF3_8000_000C);
    push_rd(1'b1, 32'h8000_1110, 3'd3, 64'h7FFF_EEEF_8000_1110);
    fork
      i_proc(2, 32'h8000_0008, lat_i);
      d_proc(3, 1'b0, 32'h8000_1100, 32'd8, 3'd3, 64'd0, 8'h00, lat_d);
    join

    // 4: write with W stalled three cycles; d_rdata keeps the last D read
    w_ready = 1'b0;
    exp_aw.push_back({32'h8000_3000, 3'd2});
    exp_w.push_back({64'h0000_0000_DEAD_BEEF, 8'h0F});
    exp_done.push_back({1'b1, 64'h7FFF_EEEF_8000_1110});
    fork
      d_proc(1, 1'b1, 32'h8000_3000, 32'd0, 3'd2, 64'h0000_0000_DEAD_BEEF, 8'h0F, lat_d);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t4_c1_valids", {62'b0, aw_valid, w_valid}, 64'd3);
        for (int k = 2; k <= 3; k++) begin
          @(negedge clk);
          chk("t4_aw_dropped_w_held", {61'b0, aw_valid, w_valid, b_ready}, 64'd2);
          chk("t4_w_data_stable", w_data, 64'h0000_0000_DEAD_BEEF);
        end
        @(posedge clk); #1;
        w_ready = 1'b1;
        @(negedge clk);
        chk("t4_c4_b_ready", {63'b0, b_ready}, 64'd0);
        @(negedge clk);
        chk("t4_c5_b_hs", {62'b0, b_ready, b_valid}, 64'd3);
      end
    join
    chk("t4_latency", 64'(lat_d), 64'd6);

    // 5: AR stalled five cycles
    ar_ready = 1'b0;
    push_rd(1'b1, 32'h8000_2008, 3'd3, 64'h7FFF_DFF7_8000_2008);
    fork
      d_proc(1, 1'b0, 32'h8000_2008, 32'd0, 3'd3, 64'd0, 8'h00, lat_d);
      begin
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          chk("t5_ar_held", {61'b0, ar_valid, ar_size}, {61'b0, 1'b1, 3'd3});
          chk("t5_ar_addr", {32'b0, ar_addr}, 64'h8000_2008);
          chk("t5_r_ready_low", {63'b0, r_ready}, 64'd0);
        end
        @(posedge clk); #1;
        ar_ready = 1'b1;
      end
    join
    chk("t5_latency", 64'(lat_d), 64'd8);

    // 6: reset while waiting in R, then a clean I read
    r_stall = 1'b1;
    exp_ar.push_back({32'h8000_0010, 3'd2});
    if_addr = 64'h8000_0010;
    if_req  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_in_r", {63'b0, r_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("t6_after_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    r_stall = 1'b0;
    push_rd(1'b0, 32'h8000_0020, 3'd2, 64'h7FFF_FFDF_8000_0020);
    i_proc(1, 32'h8000_0020, lat_i);
    chk("t6_latency", 64'(lat_i), 64'd3);

    repeat (5) @(posedge clk);
    chk("drain_done", 64'(exp_done.size()), 64'd0);
    chk("drain_ar", 64'(exp_ar.size()), 64'd0);
    chk("drain_aw_w", 64'(exp_aw.size() + exp_w.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
